// File: rtl/pb_ctrl_pkg.sv
// Shared definitions for the push-button debounce / interrupt controller.
// Latency: n/a (constants, types and one combinational helper).
// Backpressure: n/a.
//
// Contents: Avalon word offsets of the register map, the edge-capture mode
// encoding, and the edge-match helper used by every debounce channel.
package pb_ctrl_pkg;

    // Register map, word offsets on the Avalon-MM address bus.
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_EDGE   = 2'd2;
    localparam logic [1:0] ADDR_PERIOD = 2'd3;

    // Edge-capture mode, matches the EDGE_TYPE parameter values.
    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_mode_e;

    // True when the prev -> cur transition matches the requested mode.
    function automatic logic edge_hit(input logic [1:0] mode,
                                      input logic       prev,
                                      input logic       cur);
        logic hit;
        case (edge_mode_e'(mode))
            EDGE_RISE: hit = ~prev &  cur;
            EDGE_FALL: hit =  prev & ~cur;
            EDGE_ANY:  hit =  prev ^  cur;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/pb_debounce_chan.sv
// One button line: 2-FF synchroniser, optional inversion, debounce counter, stable flop, edge pulse.
// Latency: 2 sync cycles + period cycles from raw change to stable_o; edge_o is high the cycle after stable_o changes.
// Backpressure: none; free-running every clk.
//
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   raw_i         raw asynchronous button level
//   period_i      debounce period in clk cycles (0 behaves as 1)
//   stable_o      debounced level, 1 = pressed when INVERT is set
//   edge_o        one-cycle pulse when stable_o makes a transition matching EDGE_TYPE
module pb_debounce_chan
    import pb_ctrl_pkg::*;
#(
    parameter int CNT_W     = 20,
    parameter int EDGE_TYPE = 1,
    parameter bit INVERT    = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             raw_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             stable_o,
    output logic             edge_o
);

    localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};

    logic             sync1_q;
    logic             sync2_q;
    logic             synced;
    logic             stable_q;
    logic             stable_d;
    logic             stable_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W:0]   period_eff;

    // The synchroniser resets to the raw "released" level so that the
    // post-inversion value is 0 and no phantom press is seen after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= INVERT;
            sync2_q <= INVERT;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign synced = sync2_q ^ INVERT;

    // One extra bit so counter+1 and the period compare never wrap.
    assign cnt_inc    = {1'b0, cnt_q} + ONE;
    assign period_eff = (period_i == '0) ? ONE : {1'b0, period_i};

    // Using >= rather than == means that shrinking the period below the
    // current count qualifies on the next cycle instead of running away.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (synced == stable_q) begin
            cnt_d = '0;
        end else if (cnt_inc >= period_eff) begin
            stable_d = synced;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
        end
    end

    assign stable_o = stable_q;

    // Edge polarity refers to the physical pin level, so the inversion is
    // undone before matching: with active-low keys a falling pin edge is a press.
    assign edge_o = edge_hit(2'(EDGE_TYPE), stable_prev_q ^ INVERT, stable_q ^ INVERT);

endmodule

// File: rtl/pb_debounce_irq_ctrl.sv
// Avalon-MM push-button controller: debounced state, edge capture (W1C), mask and maskable level irq.
// Latency: readdata 1 cycle after address (no wait states); irq 1 cycle after capture/mask/clear changes.
// Backpressure: none; slave always accepts, writes take effect on the strobed clk edge.
//
// Ports:
//   clk, reset_n                          clock and asynchronous active-low reset
//   address, chipselect, write_n,
//   writedata, readdata                   Avalon-MM slave, 4 word registers
//   in_port                               raw asynchronous button lines
//   irq                                   level interrupt, |(edge_capture & mask)
module pb_debounce_irq_ctrl
    import pb_ctrl_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int CNT_W      = 20,
    parameter int DEF_PERIOD = 500000,
    parameter int EDGE_TYPE  = 1,
    parameter int INVERT     = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [CNT_W-1:0] DEF_PERIOD_W = CNT_W'(DEF_PERIOD);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] w1c;
    logic             wr_en;

    logic [WIDTH-1:0] mask_q,     mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [CNT_W-1:0] period_q,   period_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q,      irq_d;

    // Upper write-data bits are architecturally ignored.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        pb_debounce_chan #(
            .CNT_W     (CNT_W),
            .EDGE_TYPE (EDGE_TYPE),
            .INVERT    (INVERT != 0)
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw_i    (in_port[i]),
            .period_i (period_q),
            .stable_o (stable[i]),
            .edge_o   (edge_pulse[i])
        );
    end

    assign wr_en = chipselect & ~write_n;

    always_comb begin
        mask_d   = mask_q;
        period_d = period_q;
        w1c      = '0;
        if (wr_en) begin
            case (address)
                ADDR_MASK:   mask_d   = writedata[WIDTH-1:0];
                ADDR_EDGE:   w1c      = writedata[WIDTH-1:0];
                ADDR_PERIOD: period_d = writedata[CNT_W-1:0];
                default:     ;
            endcase
        end

        // Set is ORed in after the clear so a new edge is never lost to a
        // software clear racing it in the same cycle.
        edge_cap_d = (edge_cap_q & ~w1c) | edge_pulse;

        // Read mux samples the current register values, so an EDGE read in
        // the cycle an edge arrives returns the pre-edge capture.
        readdata_d = '0;
        case (address)
            ADDR_DATA:   readdata_d[WIDTH-1:0] = stable;
            ADDR_MASK:   readdata_d[WIDTH-1:0] = mask_q;
            ADDR_EDGE:   readdata_d[WIDTH-1:0] = edge_cap_q;
            ADDR_PERIOD: readdata_d[CNT_W-1:0] = period_q;
            default:     ;
        endcase

        irq_d = |(edge_cap_q & mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q     <= '0;
            edge_cap_q <= '0;
            period_q   <= DEF_PERIOD_W;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            edge_cap_q <= edge_cap_d;
            period_q   <= period_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pb_debounce_irq_ctrl.sv
// Directed bench for pb_debounce_irq_ctrl (default parameters: 4 keys, active-low, falling-edge capture).
// Inputs are driven 1 time unit after each rising clk edge and outputs are sampled at the same point.
// Cycle numbering in comments: the input change is applied after edge 0; edges 1, 2, ... follow.
module tb_pb_debounce_irq_ctrl;
    import pb_ctrl_pkg::*;

    localparam int WIDTH      = 4;
    localparam int CNT_W      = 20;
    localparam int DEF_PERIOD = 500000;

    logic             clk        = 1'b0;
    logic             reset_n    = 1'b0;
    logic [1:0]       address    = 2'd0;
    logic             chipselect = 1'b0;
    logic             write_n    = 1'b1;
    logic [31:0]      writedata  = 32'd0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port    = 4'hF;
    logic             irq;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pb_debounce_irq_ctrl #(
        .WIDTH      (WIDTH),
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_PERIOD),
        .EDGE_TYPE  (1),
        .INVERT     (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp;
        reset_n = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (readdata !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_readdata: got %0h expected 0", readdata);
        end
        n_vec++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
        reset_n = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            exp = (a == 3) ? 32'd500000 : 32'd0;
            n_vec++;
            if (rd !== exp) begin
                n_bad++;
                $display("FAIL reset_reg%0d: got %0d expected %0d", a, rd, exp);
            end
        end
        n_vec++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_irq_after: got %b expected 0", irq);
        end
    endtask

    // Button 1 low for 9 cycles with period 10 must never qualify.
    task automatic test_glitch();
        logic [31:0] rd;
        bus_write(ADDR_PERIOD, 32'd10);
        bus_write(ADDR_MASK, 32'h1);
        address    = ADDR_DATA;
        in_port[1] = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 9) in_port[1] = 1'b1;
            n_vec++;
            if (readdata !== 32'd0) begin
                n_bad++;
                $display("FAIL glitch_data_c%0d: got %0h expected 0", c, readdata);
            end
        end
        n_vec++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_irq: got %b expected 0", irq);
        end
        bus_read(ADDR_EDGE, rd);
        n_vec++;
        if (rd !== 32'd0) begin
            n_bad++;
            $display("FAIL glitch_edge: got %0h expected 0", rd);
        end
    endtask

    // Stable flips at edge 12 (2 sync + 10 period), DATA shows it at edge 13
    // (read latency), capture sets at edge 13, irq at edge 14.
    task automatic test_press();
        logic [31:0] rd;
        logic [31:0] exp_data;
        logic        exp_irq;
        address    = ADDR_DATA;
        in_port[0] = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            exp_data = (c >= 13) ? 32'h1 : 32'h0;
            exp_irq  = (c >= 14);
            n_vec++;
            if (readdata !== exp_data) begin
                n_bad++;
                $display("FAIL press_data_c%0d: got %0h expected %0h", c, readdata, exp_data);
            end
            n_vec++;
            if (irq !== exp_irq) begin
                n_bad++;
                $display("FAIL press_irq_c%0d: got %b expected %b", c, irq, exp_irq);
            end
        end
        repeat (6) tick();
        bus_read(ADDR_EDGE, rd);
        n_vec++;
        if (rd !== 32'h1) begin
            n_bad++;
            $display("FAIL press_edge: got %0h expected 1", rd);
        end
    endtask

    task automatic test_w1c();
        logic [31:0] rd;
        bus_write(ADDR_EDGE, 32'h1);
        n_vec++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL w1c_irq_same: got %b expected 1", irq);
        end
        tick();
        n_vec++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL w1c_irq_next: got %b expected 0", irq);
        end
        bus_read(ADDR_EDGE, rd);
        n_vec++;
        if (rd !== 32'h0) begin
            n_bad++;
            $display("FAIL w1c_edge_clear: got %0h expected 0", rd);
        end
        // Release is a rising pin edge, not captured in falling mode.
        in_port[0] = 1'b1;
        repeat (20) tick();
        bus_read(ADDR_EDGE, rd);
        n_vec++;
        if (rd !== 32'h0) begin
            n_bad++;
            $display("FAIL w1c_release_edge: got %0h expected 0", rd);
        end
        bus_read(ADDR_DATA, rd);
        n_vec++;
        if (rd !== 32'h0) begin
            n_bad++;
            $display("FAIL w1c_release_data: got %0h expected 0", rd);
        end
        // New press: edge pulse is live between edges 12 and 13; the clear
        // write lands on edge 13, so set must win.
        in_port[0] = 1'b0;
        repeat (12) tick();
        bus_write(ADDR_EDGE, 32'h1);
        n_vec++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL race_irq_same: got %b expected 0", irq);
        end
        tick();
        n_vec++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL race_irq_next: got %b expected 1", irq);
        end
        bus_read(ADDR_EDGE, rd);
        n_vec++;
        if (rd !== 32'h1) begin
            n_bad++;
            $display("FAIL race_edge: got %0h expected 1", rd);
        end
    endtask

    task automatic test_mask();
        logic [31:0] rd;
        bus_write(ADDR_EDGE, 32'hF);
        bus_write(ADDR_MASK, 32'h0);
        in_port[2] = 1'b0;
        repeat (16) tick();
        n_vec++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL mask_irq_masked: got %b expected 0", irq);
        end
        bus_read(ADDR_EDGE, rd);
        n_vec++;
        if (rd !== 32'h4) begin
            n_bad++;
            $display("FAIL mask_edge: got %0h expected 4", rd);
        end
        bus_write(ADDR_MASK, 32'hFFFF_FFF4);
        n_vec++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL mask_irq_same: got %b expected 0", irq);
        end
        tick();
        n_vec++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL mask_irq_next: got %b expected 1", irq);
        end
        bus_read(ADDR_MASK, rd);
        n_vec++;
        if (rd !== 32'h4) begin
            n_bad++;
            $display("FAIL mask_readback: got %0h expected 4", rd);
        end
    endtask

    // Period 0 behaves as 1: stable flips at edge 3, visible on DATA at edge 4.
    task automatic test_period_zero();
        logic [31:0] rd;
        logic        exp;
        bus_write(ADDR_PERIOD, 32'h0);
        bus_read(ADDR_PERIOD, rd);
        n_vec++;
        if (rd !== 32'h0) begin
            n_bad++;
            $display("FAIL pzero_readback: got %0h expected 0", rd);
        end
        address    = ADDR_DATA;
        in_port[3] = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            exp = (c == 4);
            n_vec++;
            if (readdata[3] !== exp) begin
                n_bad++;
                $display("FAIL pzero_data3_c%0d: got %b expected %b", c, readdata[3], exp);
            end
        end
        bus_read(ADDR_EDGE, rd);
        n_vec++;
        if (rd !== 32'hC) begin
            n_bad++;
            $display("FAIL pzero_edge: got %0h expected c", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic [31:0] exp;
        bus_write(ADDR_PERIOD, 32'd10);
        in_port = 4'hF;
        repeat (20) tick();
        // irq is high here (EDGE = 0xC, MASK = 0x4) and readdata shows PERIOD.
        address    = ADDR_PERIOD;
        in_port[1] = 1'b0;
        repeat (7) tick();
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (readdata !== 32'd0) begin
            n_bad++;
            $display("FAIL rmid_async_readdata: got %0h expected 0", readdata);
        end
        n_vec++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_async_irq: got %b expected 0", irq);
        end
        repeat (3) tick();
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            exp = (a == 3) ? 32'd500000 : 32'd0;
            n_vec++;
            if (rd !== exp) begin
                n_bad++;
                $display("FAIL rmid_reg%0d: got %0d expected %0d", a, rd, exp);
            end
        end
        repeat (30) tick();
        bus_read(ADDR_EDGE, rd);
        n_vec++;
        if (rd !== 32'd0) begin
            n_bad++;
            $display("FAIL rmid_edge: got %0h expected 0", rd);
        end
        n_vec++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_irq: got %b expected 0", irq);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_press();
        test_w1c();
        test_mask();
        test_period_zero();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
